apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_rr_arbiter.sv | 8 +
 rtl/apb_req_arbiter.sv | 102 ++++++++++
 tb/tb_apb_req_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB command encodings, transfer sizes and arbiter FSM states
package apb_pkg;
  localparam logic [6:0] PROC_LOAD  = 7'b0000011;
  localparam logic [6:0] PROC_STORE = 7'b0100011;
  localparam logic [6:0] PROC_NONE  = 7'b0000000;
  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;
  function automatic logic [6:0] proc_enc(input logic write);
    return write ? PROC_STORE : PROC_LOAD;
  endfunction
endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: 2-way round-robin picker; the requester not granted last wins a tie
module apb_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb grant = (&req) ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: arbitrates two requesters onto one APB master command port.
// Define APB_ARB_TIMEOUT_EN to bound the ACCESS wait to ARB_TIMEOUT cycles.
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ARB_TIMEOUT = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]              req_size,
  output logic [1:0]              rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic [DATA_WIDTH-1:0]   m_write_data,
  output logic [1:0]              m_data_size,
  output logic [6:0]              m_process,
  input  logic                    PSEL0,
  input  logic                    PSEL1,
  input  logic                    PENABLE,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   m_read_data
);
  state_t                r_state, w_next;
  logic [1:0]            w_arb, r_gnt;
  logic                  w_take, w_sel, w_timeout, w_miss;
  logic                  r_last, r_write, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_size;

  apb_rr_arbiter u_rr (.req(req_valid), .last_grant(r_last), .grant(w_arb));

  // reset gating keeps req_ready low while PRESETn is held, even in IDLE
  assign w_take = PRESETn && r_state == ST_IDLE && |req_valid && !PENABLE;
  assign w_sel  = w_arb[1];
  assign w_miss = r_state == ST_SETUP && !(PSEL0 | PSEL1);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(ARB_TIMEOUT + 1);
  logic [TW-1:0] r_cnt;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_cnt <= '0;
    else r_cnt <= (r_state == ST_ACCESS) ? r_cnt + 1'b1 : '0;
  assign w_timeout = r_state == ST_ACCESS && !(PENABLE & PREADY) && r_cnt == TW'(ARB_TIMEOUT - 1);
`else
  assign w_timeout = ARB_TIMEOUT < 0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_state <= ST_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = w_take ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:  w_next = ST_SETUP;
      ST_SETUP:  w_next = w_miss ? ST_RESP : ST_ACCESS;
      ST_ACCESS: w_next = ((PENABLE & PREADY) | w_timeout) ? ST_RESP : ST_ACCESS;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = w_take ? w_arb : 2'b00;
    m_process = (r_state == ST_ISSUE || r_state == ST_SETUP) ? proc_enc(r_write) : PROC_NONE;
    rsp_valid = (r_state == ST_RESP) ? r_gnt : 2'b00;
    rsp_err   = r_state == ST_RESP && r_err;
    rsp_rdata = (r_state == ST_RESP && !r_err && !r_write) ? m_read_data : '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= 2'b00;
      r_err   <= 1'b0;
    end else if (w_take) begin
      r_gnt   <= w_arb;
      r_last  <= w_sel;
      r_write <= req_write[w_sel];
      r_addr  <= w_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      r_wdata <= w_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      r_size  <= w_sel ? req_size[3:2] : req_size[1:0];
      r_err   <= 1'b0;
    end else if (w_miss || w_timeout) r_err <= 1'b1;

  assign m_address    = r_addr;
  assign m_write_data = r_wdata;
  assign m_data_size  = r_size;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed vectors for apb_req_arbiter with hand-computed expectations
module tb_apb_req_arbiter;
  import apb_pkg::*;
  logic        PCLK = 0, PRESETn = 1;
  logic [1:0]  req_valid = 0, req_ready, req_write = 0, rsp_valid;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_size = 0;
  logic        rsp_err, PSEL0 = 0, PSEL1 = 0, PENABLE = 0, PREADY = 0;
  logic [31:0] rsp_rdata, m_address, m_write_data, m_read_data = 32'hFFFF_FFFF;
  logic [1:0]  m_data_size;
  logic [6:0]  m_process;
  int n_chk = 0, n_err = 0;

  apb_req_arbiter dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .m_address(m_address),
    .m_write_data(m_write_data), .m_data_size(m_data_size), .m_process(m_process),
    .PSEL0(PSEL0), .PSEL1(PSEL1), .PENABLE(PENABLE), .PREADY(PREADY), .m_read_data(m_read_data)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 0);
    check({tag, "_cmd"}, {m_address, m_write_data}, 0);
    check({tag, "_ctl"}, {m_data_size, m_process}, 0);
  endtask

  // requester 1 sees address a^0x100 and data ~d so slice selection is observable
  task automatic xfer(input logic [1:0] v, input logic [1:0] g, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] s, input logic sel, input int wt,
                      input logic hold, input logic [31:0] rd, input logic er, input int lat);
    int c;
    logic [31:0] ea, ed;
    ea = g[1] ? a ^ 32'h100 : a;
    ed = g[1] ? ~d : d;
    @(posedge PCLK); #1;
    req_valid = v; req_write = {w, w}; req_addr = {a ^ 32'h100, a};
    req_wdata = {~d, d}; req_size = {s, s}; m_read_data = rd;
    PSEL0 = 0; PENABLE = 0; PREADY = 0;
    @(negedge PCLK);
    check("grant", req_ready, g);
    c = 0;
    do begin
      @(posedge PCLK); #1;
      c++;
      if (!hold) req_valid = 0;
      PSEL0   = sel && c >= 2 && c <= 3 + wt;
      PENABLE = sel && c >= 3 && c <= 3 + wt;
      PREADY  = sel && c == 3 + wt;
      @(negedge PCLK);
      if (c == 1) begin
        check("busy", req_ready, 0);
        check("addr", m_address, ea);
        check("wdata", m_write_data, ed);
        check("size", m_data_size, s);
      end
      if (c <= 2) check("proc", m_process, w ? PROC_STORE : PROC_LOAD);
      if (c == 3) check("proc_access", m_process, PROC_NONE);
    end while (rsp_valid == 0 && c < lat + 2);
    check("latency", c, lat);
    check("rsp_valid", rsp_valid, g);
    check("rsp_err", rsp_err, er);
    check("rsp_rdata", rsp_rdata, (er || w) ? 32'h0 : rd);
  endtask

  initial begin
    req_valid = 2'b11;
    #2 PRESETn = 0;
    #10 check_zero("reset");
    @(negedge PCLK);
    req_valid = 0; PRESETn = 1;
    for (int i = 0; i < 4; i++)
      xfer(2'b11, (i % 2) ? 2'b10 : 2'b01, 0, 32'd4001, 32'hA0 + i, SIZE_WORD, 1, 0, 1, 32'h1000 + i, 0, 4);
    xfer(2'b01, 2'b01, 0, 32'd4000, 32'h0, SIZE_WORD, 1, 0, 0, 32'hDEADBEEF, 0, 4);
    xfer(2'b10, 2'b10, 1, 32'h10, 32'hCAFE, SIZE_BYTE, 0, 0, 0, 32'h77, 1, 3);
    xfer(2'b01, 2'b01, 0, 32'h300, 32'h0, SIZE_HALF, 1, 5, 0, 32'h12345678, 0, 9);
    xfer(2'b10, 2'b10, 1, 32'h400, 32'h89ABCDEF, SIZE_HALF, 1, 1, 0, 32'hFFFF, 0, 5);
`ifdef APB_ARB_TIMEOUT_EN
    xfer(2'b01, 2'b01, 0, 32'h200, 32'h0, SIZE_WORD, 1, 1000, 0, 32'h55, 1, 19);
    @(posedge PCLK); #1;
    req_valid = 2'b10;
    @(negedge PCLK);
    check("penable_block", req_ready, 0);
`else
    xfer(2'b01, 2'b01, 0, 32'h200, 32'h0, SIZE_WORD, 1, 30, 0, 32'h55, 0, 34);
`endif
    // last grant is requester 0 here, so a missing last_grant reset would favour requester 1
    @(posedge PCLK); #1;
    req_valid = 2'b01; req_write = 0; PSEL0 = 0; PENABLE = 0; PREADY = 0;
    @(negedge PCLK);
    check("mid_grant", req_ready, 2'b01);
    @(posedge PCLK); #1; req_valid = 0;
    @(posedge PCLK); #1; PSEL0 = 1;
    @(posedge PCLK); #1; PENABLE = 1;
    repeat (2) @(posedge PCLK);
    #3;
    req_valid = 2'b11; PENABLE = 0; PSEL0 = 0; PRESETn = 0;
    #1 check_zero("mid_reset");
    @(posedge PCLK); #1 check_zero("held_reset");
    @(negedge PCLK);
    req_valid = 0; PRESETn = 1;
    xfer(2'b11, 2'b01, 0, 32'd4001, 32'h5A, SIZE_WORD, 1, 0, 0, 32'h600D, 0, 4);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
